// File: rtl/ifu_icache_fa.sv
// Fully-associative instruction cache for the IFU.
// Single-cycle hit lookup across all entries; a miss fetches one whole line
// over the fill port, installs it and answers the pending request from it.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A producer raising valid keeps it and its payload stable until that
// edge. rsp_valid is a one-cycle pulse with no backpressure.
module ifu_icache_fa #(
    parameter int NUM_LINES      = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int INSTR_WIDTH    = 32,
    parameter int MISS_CNT_WIDTH = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      rsp_valid,
    output logic [INSTR_WIDTH-1:0]    rsp_instr,
    output logic                      fill_req_valid,
    input  logic                      fill_req_ready,
    output logic [ADDR_WIDTH-1:0]     fill_req_addr,
    input  logic                      fill_rsp_valid,
    input  logic [LINE_WIDTH-1:0]     fill_rsp_line,
    input  logic                      flush,
    output logic [MISS_CNT_WIDTH-1:0] miss_count,
    output logic [1:0]                dbg_state,
    output logic [$clog2(NUM_LINES)-1:0] dbg_rr_ptr
);

    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int WORD_LSB     = $clog2(INSTR_WIDTH / 8);
    localparam int WORDS        = LINE_WIDTH / INSTR_WIDTH;
    localparam int WORD_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IDX_W        = $clog2(NUM_LINES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]      tag_q  [NUM_LINES];
    logic [LINE_WIDTH-1:0]     data_q [NUM_LINES];
    logic [IDX_W-1:0]          rr_ptr_q;
    logic [TAG_WIDTH-1:0]      miss_tag_q;
    logic [WORD_W-1:0]         miss_word_q;
    logic [MISS_CNT_WIDTH-1:0] miss_cnt_q;
    logic                      rsp_valid_q;
    logic [INSTR_WIDTH-1:0]    rsp_instr_q;

    logic [TAG_WIDTH-1:0]      req_tag;
    logic [WORD_W-1:0]         req_word;
    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;
    logic [LINE_WIDTH-1:0]     hit_line;
    logic [INSTR_WIDTH-1:0]    hit_instr;
    logic                      has_inv;
    logic [IDX_W-1:0]          inv_idx;
    logic [IDX_W-1:0]          victim;
    logic                      acc_hit;
    logic                      acc_miss;
    logic                      install;

    assign req_tag  = req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign req_word = WORD_W'(req_addr[OFFSET_WIDTH-1:0] >> WORD_LSB);

    // Tag match across every entry; tags are unique so at most one matches.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_line  = data_q[hit_idx];
    assign hit_instr = hit_line[req_word*INSTR_WIDTH +: INSTR_WIDTH];

    // Victim: lowest-index invalid entry, otherwise the round-robin pointer.
    always_comb begin
        has_inv = 1'b0;
        inv_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_inv = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
    end

    assign victim = has_inv ? inv_idx : rr_ptr_q;

    // Miss FSM: next state and handshake outputs, defaults first.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        fill_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush && !hit) begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                fill_req_valid = 1'b1;
                if (fill_req_ready) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (fill_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_hit  = req_valid && req_ready && hit;
    assign acc_miss = req_valid && req_ready && !hit;
    assign install  = (state_q == MISS_WAIT) && fill_rsp_valid;

    // Control, bookkeeping and response registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            rr_ptr_q    <= '0;
            miss_tag_q  <= '0;
            miss_word_q <= '0;
            miss_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (acc_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_instr_q <= hit_instr;
            end
            if (acc_miss) begin
                miss_tag_q  <= req_tag;
                miss_word_q <= req_word;
                if (miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + MISS_CNT_WIDTH'(1);
                end
            end
            // A flush clears everything; an install in the same cycle wins for its entry.
            if (flush) begin
                valid_q <= '0;
            end
            if (install) begin
                valid_q[victim] <= 1'b1;
                tag_q[victim]   <= miss_tag_q;
                rsp_valid_q     <= 1'b1;
                rsp_instr_q     <= fill_rsp_line[miss_word_q*INSTR_WIDTH +: INSTR_WIDTH];
                if (!has_inv) begin
                    rr_ptr_q <= rr_ptr_q + IDX_W'(1);
                end
            end
        end
    end

    // Line storage is not reset; valid bits guard it.
    always_ff @(posedge Clk) begin
        if (install && !Rst) begin
            data_q[victim] <= fill_rsp_line;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_instr     = rsp_instr_q;
    assign fill_req_addr = {miss_tag_q, {OFFSET_WIDTH{1'b0}}};
    assign miss_count    = miss_cnt_q;
    assign dbg_state     = state_q;
    assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_ifu_icache_fa.sv
// Directed bench for ifu_icache_fa: hits, misses, replacement, flush,
// counter saturation (8-bit counter instance) and reset during a miss.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_ifu_icache_fa;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic         rsp_valid;
    logic [31:0]  rsp_instr;
    logic         fill_req_valid;
    logic         fill_req_ready = 1'b0;
    logic [31:0]  fill_req_addr;
    logic         fill_rsp_valid = 1'b0;
    logic [127:0] fill_rsp_line = '0;
    logic         flush = 1'b0;
    logic [7:0]   miss_count;
    logic [1:0]   dbg_state;
    logic [3:0]   dbg_rr_ptr;

    int total = 0;
    int bad   = 0;

    ifu_icache_fa #(
        .NUM_LINES(16), .ADDR_WIDTH(32), .LINE_WIDTH(128),
        .INSTR_WIDTH(32), .MISS_CNT_WIDTH(8)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
        .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
        .fill_req_addr(fill_req_addr),
        .fill_rsp_valid(fill_rsp_valid), .fill_rsp_line(fill_rsp_line),
        .flush(flush), .miss_count(miss_count),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Clock
    always #5 Clk = ~Clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line whose word k holds the byte address of that word.
    function automatic logic [127:0] line_for(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFF0;
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    // Present one request at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    // From MISS_REQ: handshake immediately, return the line next cycle.
    task automatic finish_fill(input logic [127:0] line, input logic [31:0] exp_instr);
        fill_req_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        fill_req_ready = 1'b0;
        chk("state_wait", 32'(dbg_state), 32'd2);
        fill_rsp_valid = 1'b1;
        fill_rsp_line  = line;
        @(posedge Clk);
        @(negedge Clk);
        fill_rsp_valid = 1'b0;
        chk("fill_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fill_rsp_instr", rsp_instr, exp_instr);
        chk("ready_after_fill", 32'(req_ready), 32'd1);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_cnt);
        issue(addr);
        chk("miss_fill_valid", 32'(fill_req_valid), 32'd1);
        chk("miss_fill_addr", fill_req_addr, addr & 32'hFFFF_FFF0);
        chk("miss_no_rsp", 32'(rsp_valid), 32'd0);
        chk("miss_count", 32'(miss_count), exp_cnt);
        finish_fill(line_for(addr), addr);
    endtask

    task automatic do_hit(input logic [31:0] addr);
        issue(addr);
        chk("hit_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hit_rsp_instr", rsp_instr, addr);
        chk("hit_no_fill", 32'(fill_req_valid), 32'd0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_fill_valid", 32'(fill_req_valid), 32'd0);
        chk("rst_fill_addr", fill_req_addr, 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);

        // First miss, with fill_req_ready held low and a stray fill response
        issue(32'h0000_1004);
        chk("m1_fill_valid", 32'(fill_req_valid), 32'd1);
        chk("m1_fill_addr", fill_req_addr, 32'h0000_1000);
        chk("m1_miss_count", 32'(miss_count), 32'd1);
        for (int c = 0; c < 5; c++) begin
            fill_rsp_valid = (c == 2);
            fill_rsp_line  = {4{32'hBAD0_BAD0}};
            @(posedge Clk);
            @(negedge Clk);
            fill_rsp_valid = 1'b0;
            chk("stall_fill_valid", 32'(fill_req_valid), 32'd1);
            chk("stall_fill_addr", fill_req_addr, 32'h0000_1000);
            chk("stall_state", 32'(dbg_state), 32'd1);
            chk("stall_no_rsp", 32'(rsp_valid), 32'd0);
        end
        finish_fill({32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111}, 32'hDEAD_BEEF);

        // Back-to-back hits
        req_valid = 1'b1;
        req_addr  = 32'h0000_1000;
        @(posedge Clk);
        @(negedge Clk);
        req_addr = 32'h0000_1008;
        chk("b2b0_valid", 32'(rsp_valid), 32'd1);
        chk("b2b0_instr", rsp_instr, 32'h1111_1111);
        @(posedge Clk);
        @(negedge Clk);
        req_addr = 32'h0000_100C;
        chk("b2b1_valid", 32'(rsp_valid), 32'd1);
        chk("b2b1_instr", rsp_instr, 32'h3333_3333);
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        chk("b2b2_valid", 32'(rsp_valid), 32'd1);
        chk("b2b2_instr", rsp_instr, 32'h4444_4444);
        chk("b2b_no_fill", 32'(fill_req_valid), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rsp_hold", rsp_instr, 32'h4444_4444);
        chk("b2b_miss_count", 32'(miss_count), 32'd1);

        // Flush in IDLE together with a request
        req_valid = 1'b1;
        req_addr  = 32'h0000_1000;
        flush     = 1'b1;
        #1;
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
        chk("flush_state", 32'(dbg_state), 32'd0);
        do_miss(32'h0000_1000, 32'd2);

        // Empty the cache, then fill 17 distinct lines
        flush = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        flush = 1'b0;
        for (int i = 0; i < 17; i++) begin
            do_miss(32'h0000_2000 + 32'(i) * 32'h10 + 32'(i % 4) * 32'd4, 32'(3 + i));
            if (i == 15) chk("rr_after_16", 32'(dbg_rr_ptr), 32'd0);
        end
        chk("rr_after_17", 32'(dbg_rr_ptr), 32'd1);
        do_hit(32'h0000_2014);
        do_miss(32'h0000_2000, 32'd20);
        chk("rr_after_18", 32'(dbg_rr_ptr), 32'd2);
        do_hit(32'h0000_2028);

        // Flush during MISS_WAIT, then flush coinciding with the install
        issue(32'h0000_3000);
        chk("fw_fill_valid", 32'(fill_req_valid), 32'd1);
        fill_req_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        fill_req_ready = 1'b0;
        flush = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("fw_not_aborted", 32'(dbg_state), 32'd2);
        fill_rsp_valid = 1'b1;
        fill_rsp_line  = line_for(32'h0000_3000);
        @(posedge Clk);
        @(negedge Clk);
        flush          = 1'b0;
        fill_rsp_valid = 1'b0;
        chk("fw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fw_rsp_instr", rsp_instr, 32'h0000_3000);
        chk("fw_miss_count", 32'(miss_count), 32'd21);
        do_hit(32'h0000_3004);
        do_miss(32'h0000_2028, 32'd22);

        // Counter saturation (8-bit instance)
        for (int k = 0; k < 232; k++) begin
            do_miss(32'h0001_0000 + 32'(k) * 32'h10 + 32'(k % 4) * 32'd4, 32'(23 + k));
        end
        do_miss(32'h0001_0E80, 32'd255);
        do_miss(32'h0001_0E94, 32'd255);

        // Reset in MISS_WAIT, then a late fill response
        issue(32'h0000_5000);
        fill_req_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        fill_req_ready = 1'b0;
        chk("rw_state", 32'(dbg_state), 32'd2);
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        fill_rsp_valid = 1'b1;
        fill_rsp_line  = line_for(32'h0000_5000);
        #1;
        chk("rw_state_idle", 32'(dbg_state), 32'd0);
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_rsp_instr", rsp_instr, 32'd0);
        chk("rw_fill_valid", 32'(fill_req_valid), 32'd0);
        chk("rw_fill_addr", fill_req_addr, 32'd0);
        chk("rw_miss_count", 32'(miss_count), 32'd0);
        chk("rw_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        fill_rsp_valid = 1'b0;
        chk("late_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("late_rsp_instr", rsp_instr, 32'd0);
        chk("late_state", 32'(dbg_state), 32'd0);
        do_miss(32'h0000_5008, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
